// File: rtl/rv_mem_arbiter.sv
// Two-requester arbiter/sequencer for the shared instruction/data memory.
// One transaction at a time, fixed memory latency, round-robin on ties.
module rv_mem_arbiter #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    state_t     state;
    logic       last_ls;
    logic       cur_ls;
    logic       cur_we;
    logic [2:0] lat_cnt;
    logic       pick_ls;

    // On a tie the requester that did not own the previous grant wins.
    always_comb begin
        pick_ls = ls_req && !(if_req && last_ls);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            last_ls   <= 1'b1;
            cur_ls    <= 1'b0;
            cur_we    <= 1'b0;
            lat_cnt   <= 3'd0;
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_gnt    <= 1'b0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            case (state)
                IDLE: begin
                    busy <= if_req || ls_req;
                    if (if_req || ls_req) begin
                        cur_ls    <= pick_ls;
                        last_ls   <= pick_ls;
                        cur_we    <= pick_ls && ls_we;
                        if_gnt    <= !pick_ls;
                        ls_gnt    <= pick_ls;
                        mem_en    <= 1'b1;
                        mem_we    <= pick_ls && ls_we;
                        mem_addr  <= pick_ls ? ls_addr : if_addr;
                        mem_wdata <= pick_ls ? ls_wdata : '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    lat_cnt <= 3'd1;
                    state   <= (MEM_LAT > 1) ? WAIT : RESP;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lat_cnt == LAT_LAST) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    // mem_rdata is valid this cycle; the response shows one cycle later.
                    if (cur_ls) begin
                        ls_rvalid <= 1'b1;
                        ls_rdata  <= cur_we ? '0 : mem_rdata;
                    end else begin
                        if_rvalid <= 1'b1;
                        if_rdata  <= mem_rdata;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
